// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared definitions for the pattern scan controller.
//   state_e : controller FSM encoding (idle / shifting bits / result pending)
//   RstPat  : default pattern loaded into the pattern register at reset
package pattern_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam logic [3:0] RstPat = 4'b1010;

endpackage

// File: rtl/pattern_det_core.sv
// Bit-serial Moore-style pattern detector.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   clear     : drop history and fill (start of a new word)
//   bit_valid : bit_in is consumed this cycle
//   bit_in    : serial data bit
//   pattern   : pattern to match, MSB is the oldest bit
//   overlap   : 1 = overlapping matches, 0 = each match needs PAT_W fresh bits
//   hit_now   : combinational match on the bit consumed this cycle
//   hit       : hit_now registered (one-cycle pulse, one cycle later)
module pattern_det_core #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit_now,
  output logic             hit
);

  localparam int unsigned       FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             hit_q;

  logic [PAT_W:0]   hist_ext;
  logic [PAT_W-1:0] hist_shift;
  logic [FillW-1:0] fill_inc;

  always_comb begin
    hist_ext   = {hist_q, bit_in};
    hist_shift = hist_ext[PAT_W-1:0];
    // fill counts valid history bits and saturates at PAT_W
    fill_inc   = (fill_q == FillFull) ? FillFull : fill_q + 1'b1;
    hit_now    = bit_valid && (fill_inc == FillFull) && (hist_shift == pattern);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d = hist_shift;
      // non-overlap: forget the matched bits so the next match needs a full new window
      fill_d = (hit_now && !overlap) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hit_q  <= hit_now;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans parallel words MSB-first through a serial pattern detector and reports
// the per-word match count.
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-low reset
//   cfg_we          : config write, honoured only while idle
//   cfg_pattern     : pattern to detect, MSB = first bit in time
//   cfg_overlap     : 1 = overlapping detection
//   in_valid/ready  : input word handshake, in_data is the word
//   out_valid/ready : result handshake, out_count is the saturating match count
//   hit             : one-cycle pulse the cycle after a completing bit
//   busy            : high while shifting or holding a result
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int unsigned      DATA_W  = 16,
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 5,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(RstPat)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              hit,
  output logic              busy
);

  localparam int unsigned         BitCntW = $clog2(DATA_W + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CntMax  = '1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic                ovl_q, ovl_d;

  logic det_clear;
  logic bit_valid;
  logic hit_now;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    det_clear = 1'b0;
    bit_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        // config latched here is already in pat_q when the first bit is scanned
        if (cfg_we) begin
          pat_d = cfg_pattern;
          ovl_d = cfg_overlap;
        end
        if (in_valid) begin
          shift_d   = in_data;
          bit_cnt_d = '0;
          count_d   = '0;
          det_clear = 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        bit_valid = 1'b1;
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (hit_now && (count_q != CntMax)) begin
          count_d = count_q + 1'b1;
        end
        if (bit_cnt_q == LastBit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      count_q   <= '0;
      pat_q     <= RST_PAT;
      ovl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
    end
  end

  pattern_det_core #(
    .PAT_W (PAT_W)
  ) u_det (
    .clk       (clk),
    .rst       (rst),
    .clear     (det_clear),
    .bit_valid (bit_valid),
    .bit_in    (shift_q[DATA_W-1]),
    .pattern   (pat_q),
    .overlap   (ovl_q),
    .hit_now   (hit_now),
    .hit       (hit)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_count = count_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: the driver pushes the hand-computed
// match count of each word; a monitor pops on every result handshake and checks
// count, observed hit pulses and result latency.
module tb_pattern_scan_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_we = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic              cfg_overlap = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  out_count;
  logic              hit;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int hit_cnt  = 0;
  logic ov_prev = 1'b0;
  int exp_q[$];

  pattern_scan_ctrl #(
    .DATA_W  (DATA_W),
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .RST_PAT (4'b1010)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .hit         (hit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Acceptance is sampled on the active edge so it cannot race the driver.
  always @(posedge clk) begin
    if (rst && in_valid && in_ready) begin
      acc_cyc = cyc;
      hit_cnt = 0;
    end
    cyc++;
  end

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (hit) hit_cnt++;
      if (out_valid && !ov_prev) check("latency", cyc - acc_cyc, DATA_W + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("out_count", int'(out_count), e);
          check("hit_pulses", hit_cnt, e);
        end
      end
      ov_prev = out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the word is presented.
  task automatic send(input logic [DATA_W-1:0] d, input int exp, input logic do_cfg,
                      input logic [PAT_W-1:0] pat, input logic ovl);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    in_data     = d;
    in_valid    = 1'b1;
    cfg_we      = do_cfg;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic wait_ov();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_wait", int'(out_valid), 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // 1. reset
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_busy", int'(busy), 0);

    // 2. default config, stalled result
    out_ready = 1'b0;
    send(16'hAAAA, 4, 1'b0, 4'b0000, 1'b0);
    check("busy_shift", int'(busy), 1);
    wait_ov();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      check("stall_count", int'(out_count), 4);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("idle_busy", int'(busy), 0);
    check("idle_out_valid", int'(out_valid), 0);
    check("count_kept", int'(out_count), 4);

    // 3. overlap and all-ones patterns, back to back
    send(16'hAAAA, 7, 1'b1, 4'b1010, 1'b1);
    send(16'hFFFF, 4, 1'b1, 4'b1111, 1'b0);
    send(16'hFFFF, 13, 1'b1, 4'b1111, 1'b1);
    drain();

    // 4. final-bit match and word boundaries
    send(16'h000A, 1, 1'b1, 4'b1010, 1'b0);
    wait_ov();
    check("hit_first_done", int'(hit), 1);
    send(16'h0000, 0, 1'b1, 4'b1010, 1'b1);
    send(16'h0005, 0, 1'b0, 4'b0000, 1'b0);
    send(16'h0000, 0, 1'b0, 4'b0000, 1'b0);
    drain();

    // 5. config writes during SHIFT ignored, in IDLE applied
    send(16'h6666, 0, 1'b1, 4'b1010, 1'b0);
    @(negedge clk);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = 4'b0110;
    cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    send(16'h6666, 0, 1'b0, 4'b0000, 1'b0);
    drain();
    cfg_we      = 1'b1;
    cfg_pattern = 4'b0110;
    cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    send(16'h6666, 4, 1'b0, 4'b0000, 1'b0);
    drain();

    // 6. reset in the 6th SHIFT cycle
    send(16'hAAAA, 0, 1'b1, 4'b0101, 1'b1);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_count", int'(out_count), 1);
    check("pre_rst_hit", int'(hit), 1);
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_count", int'(out_count), 0);
    check("mid_rst_hit", int'(hit), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    send(16'hAAAA, 4, 1'b0, 4'b0000, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
